// File: rtl/rob_commit.sv
// Reorder buffer storage with in-order retire from the head.
// Drives register-file writeback and reservation-station release pulses.
module rob_commit #(
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_func,
  input  logic [REG_AW-1:0] alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic              commit_valid,
  output logic              commit_we,
  output logic [REG_AW-1:0] commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              free_add,
  output logic              free_mul,
  output logic [TAG_W:0]    count,
  output logic              full,
  output logic              empty
);

  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_MUL,
    CLS_BR
  } fclass_e;

  localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(ROB_DEPTH);

  function automatic fclass_e classify(input logic [3:0] f);
    case (f[3:1])
      3'b000:  return CLS_ADD;
      3'b001:  return CLS_MUL;
      default: return CLS_BR;
    endcase
  endfunction

  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] ready_q, ready_d;
  logic [3:0]           func_q [ROB_DEPTH];
  logic [3:0]           func_d [ROB_DEPTH];
  logic [REG_AW-1:0]    rd_q   [ROB_DEPTH];
  logic [REG_AW-1:0]    rd_d   [ROB_DEPTH];
  logic [DATA_W-1:0]    data_q [ROB_DEPTH];
  logic [DATA_W-1:0]    data_d [ROB_DEPTH];

  logic [TAG_W-1:0]     head_q, head_d;
  logic [TAG_W-1:0]     tail_q, tail_d;
  logic [TAG_W:0]       count_q, count_d;

  logic                 cvalid_q, cvalid_d;
  logic                 cwe_q, cwe_d;
  logic [REG_AW-1:0]    crd_q, crd_d;
  logic [DATA_W-1:0]    cdata_q, cdata_d;
  logic [TAG_W-1:0]     ctag_q, ctag_d;
  logic                 fadd_q, fadd_d;
  logic                 fmul_q, fmul_d;

  logic                 alloc_acc;
  logic                 retire;
  fclass_e              head_cls;

  assign full        = (count_q == DEPTH_CNT);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign alloc_ready = !full;
  assign alloc_tag   = tail_q;

  assign commit_valid = cvalid_q;
  assign commit_we    = cwe_q;
  assign commit_rd    = crd_q;
  assign commit_data  = cdata_q;
  assign commit_tag   = ctag_q;
  assign free_add     = fadd_q;
  assign free_mul     = fmul_q;

  // Alloc is judged on pre-edge occupancy, so a same-cycle retire never frees a slot early.
  assign alloc_acc = alloc_valid && !full;
  assign retire    = valid_q[head_q] && ready_q[head_q];
  assign head_cls  = classify(func_q[head_q]);

  always_comb begin
    valid_d  = valid_q;
    ready_d  = ready_q;
    func_d   = func_q;
    rd_d     = rd_q;
    data_d   = data_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    cvalid_d = 1'b0;
    cwe_d    = 1'b0;
    fadd_d   = 1'b0;
    fmul_d   = 1'b0;
    crd_d    = crd_q;
    cdata_d  = cdata_q;
    ctag_d   = ctag_q;

    if (flush) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // The alloc target is never valid pre-edge, so a CDB hitting it is dropped here.
      if (cdb_valid && valid_q[cdb_tag]) begin
        ready_d[cdb_tag] = 1'b1;
        data_d[cdb_tag]  = cdb_data;
      end

      if (retire) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + TAG_W'(1);
        cvalid_d        = 1'b1;
        cwe_d           = (head_cls != CLS_BR);
        fadd_d          = (head_cls == CLS_ADD);
        fmul_d          = (head_cls == CLS_MUL);
        crd_d           = rd_q[head_q];
        cdata_d         = data_q[head_q];
        ctag_d          = head_q;
      end

      if (alloc_acc) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        func_d[tail_q]  = alloc_func;
        rd_d[tail_q]    = alloc_rd;
        tail_d          = tail_q + TAG_W'(1);
      end

      count_d = count_q + (TAG_W+1)'(alloc_acc) - (TAG_W+1)'(retire);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      valid_q  <= '0;
      ready_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cvalid_q <= 1'b0;
      cwe_q    <= 1'b0;
      fadd_q   <= 1'b0;
      fmul_q   <= 1'b0;
      crd_q    <= '0;
      cdata_q  <= '0;
      ctag_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cvalid_q <= cvalid_d;
      cwe_q    <= cwe_d;
      fadd_q   <= fadd_d;
      fmul_q   <= fmul_d;
      crd_q    <= crd_d;
      cdata_q  <= cdata_d;
      ctag_q   <= ctag_d;
    end
  end

  // Payload is qualified by valid/ready, so it needs no reset.
  always_ff @(posedge clk1) begin
    func_q <= func_d;
    rd_q   <= rd_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed, table-driven bench for rob_commit: one vector per clock cycle.
// Expected outputs are hand-computed; ed < 0 marks the commit payload as don't-care.
module tb_rob_commit;

  logic        clk1;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  alloc_func;
  logic [3:0]  alloc_rd;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        flush;
  logic        commit_valid;
  logic        commit_we;
  logic [3:0]  commit_rd;
  logic [15:0] commit_data;
  logic [2:0]  commit_tag;
  logic        free_add;
  logic        free_mul;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int n_cmp = 0;
  int n_bad = 0;

  rob_commit #(
    .ROB_DEPTH(8),
    .TAG_W(3),
    .DATA_W(16),
    .REG_AW(4)
  ) dut (
    .clk1(clk1),
    .rst(rst),
    .alloc_valid(alloc_valid),
    .alloc_func(alloc_func),
    .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
    .flush(flush),
    .commit_valid(commit_valid),
    .commit_we(commit_we),
    .commit_rd(commit_rd),
    .commit_data(commit_data),
    .commit_tag(commit_tag),
    .free_add(free_add),
    .free_mul(free_mul),
    .count(count),
    .full(full),
    .empty(empty)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    logic        av;
    logic [3:0]  f;
    logic [3:0]  rd;
    logic        cv;
    logic [2:0]  ct;
    logic [15:0] cd;
    logic        fl;
    logic        rs;
    logic        e_cv;
    logic        e_we;
    logic [3:0]  e_rd;
    logic [15:0] e_data;
    logic [2:0]  e_tag;
    logic        e_fa;
    logic        e_fm;
    logic [3:0]  e_cnt;
    logic [2:0]  e_atag;
    logic        chk;
  } vec_t;

  function automatic vec_t mk(input int av, input int f, input int rd,
                              input int cv, input int ct, input int cd,
                              input int fl, input int rs,
                              input int ecv, input int ewe, input int erd,
                              input int ed, input int et, input int efa,
                              input int efm, input int ecnt, input int eat);
    vec_t r;
    r.av     = 1'(av);
    r.f      = 4'(f);
    r.rd     = 4'(rd);
    r.cv     = 1'(cv);
    r.ct     = 3'(ct);
    r.cd     = 16'(cd);
    r.fl     = 1'(fl);
    r.rs     = 1'(rs);
    r.e_cv   = 1'(ecv);
    r.e_we   = 1'(ewe);
    r.e_rd   = 4'(erd);
    r.e_data = 16'(ed);
    r.e_tag  = 3'(et);
    r.e_fa   = 1'(efa);
    r.e_fm   = 1'(efm);
    r.e_cnt  = 4'(ecnt);
    r.e_atag = 3'(eat);
    r.chk    = (ed >= 0);
    return r;
  endfunction

  task automatic check(input string nm, input vec_t v);
    logic ok;
    logic efull;
    logic eempty;
    efull  = (v.e_cnt == 4'd8);
    eempty = (v.e_cnt == 4'd0);
    ok = (commit_valid === v.e_cv) && (commit_we === v.e_we) &&
         (free_add === v.e_fa) && (free_mul === v.e_fm) &&
         (count === v.e_cnt) && (full === efull) && (empty === eempty) &&
         (alloc_ready === !efull) && (alloc_tag === v.e_atag);
    if (v.chk)
      ok = ok && (commit_rd === v.e_rd) && (commit_data === v.e_data) &&
           (commit_tag === v.e_tag);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got cv=%0b we=%0b fa=%0b fm=%0b rd=%0d data=%h tag=%0d cnt=%0d full=%0b empty=%0b rdy=%0b atag=%0d ; want cv=%0b we=%0b fa=%0b fm=%0b rd=%0d data=%h tag=%0d (payload checked=%0b) cnt=%0d atag=%0d",
               nm, commit_valid, commit_we, free_add, free_mul, commit_rd, commit_data,
               commit_tag, count, full, empty, alloc_ready, alloc_tag,
               v.e_cv, v.e_we, v.e_fa, v.e_fm, v.e_rd, v.e_data, v.e_tag, v.chk,
               v.e_cnt, v.e_atag);
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    alloc_valid = v.av;
    alloc_func  = v.f;
    alloc_rd    = v.rd;
    cdb_valid   = v.cv;
    cdb_tag     = v.ct;
    cdb_data    = v.cd;
    flush       = v.fl;
    rst         = v.rs;
    @(posedge clk1);
    #1;
    check(nm, v);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vt[$];
  localparam int D = -1;

  initial begin
    // reset, then fill to full with add ops rd 1..8; 9th alloc ignored
    vt.push_back(mk(0,0,0, 0,0,0, 0,1, 0,0,0,0,0,0,0, 0,0));
    for (int i = 1; i <= 8; i++)
      vt.push_back(mk(1,0,i, 0,0,0, 0,0, 0,0,0,0,0,0,0, i,i%8));
    vt.push_back(mk(1,0,9, 0,0,0, 0,0, 0,0,0,0,0,0,0, 8,0));
    // out-of-order completion: 2,1,0 then in-order retire
    vt.push_back(mk(0,0,0, 1,2,'h22, 0,0, 0,0,0,0,0,0,0, 8,0));
    vt.push_back(mk(0,0,0, 1,1,'h11, 0,0, 0,0,0,0,0,0,0, 8,0));
    vt.push_back(mk(0,0,0, 1,0,'h00, 0,0, 0,0,0,0,0,0,0, 8,0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,1,'h0000,0,1,0, 7,0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,2,'h0011,1,1,0, 6,0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,3,'h0022,2,1,0, 5,0));
    vt.push_back(mk(0,0,0, 1,3,'h33, 0,0, 0,0,3,'h0022,2,0,0, 5,0));
    vt.push_back(mk(0,0,0, 1,4,'h44, 0,0, 1,1,4,'h0033,3,1,0, 4,0));
    vt.push_back(mk(0,0,0, 1,5,'h55, 0,0, 1,1,5,'h0044,4,1,0, 3,0));
    // alloc + retire in the same cycle, then wrap-around allocs 0..3
    vt.push_back(mk(1,0,9,  0,0,0, 0,0, 1,1,6,'h0055,5,1,0, 3,1));
    vt.push_back(mk(1,0,10, 0,0,0, 0,0, 0,0,6,'h0055,5,0,0, 4,2));
    vt.push_back(mk(1,0,11, 0,0,0, 0,0, 0,0,6,'h0055,5,0,0, 5,3));
    vt.push_back(mk(1,0,12, 0,0,0, 0,0, 0,0,6,'h0055,5,0,0, 6,4));
    vt.push_back(mk(0,0,0, 1,6,'h66, 0,0, 0,0,6,'h0055,5,0,0, 6,4));
    vt.push_back(mk(0,0,0, 1,7,'h77, 0,0, 1,1,7,'h0066,6,1,0, 5,4));
    vt.push_back(mk(0,0,0, 1,0,'hA0, 0,0, 1,1,8,'h0077,7,1,0, 4,4));
    vt.push_back(mk(0,0,0, 1,1,'hA1, 0,0, 1,1,9,'h00A0,0,1,0, 3,4));
    vt.push_back(mk(0,0,0, 1,2,'hA2, 0,0, 1,1,10,'h00A1,1,1,0, 2,4));
    vt.push_back(mk(0,0,0, 1,3,'hA3, 0,0, 1,1,11,'h00A2,2,1,0, 1,4));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,12,'h00A3,3,1,0, 0,4));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,12,'h00A3,3,0,0, 0,4));
    // refill to full from head=4; head becomes ready on the last alloc
    for (int i = 1; i <= 7; i++)
      vt.push_back(mk(1,0,i, 0,0,0, 0,0, 0,0,12,'h00A3,3,0,0, i,(4+i)%8));
    vt.push_back(mk(1,0,8, 1,4,'h1234, 0,0, 0,0,12,'h00A3,3,0,0, 8,4));
    // full: retire happens, alloc rejected; next cycle alloc accepted
    vt.push_back(mk(1,4'b0100,13, 0,0,0, 0,0, 1,1,1,'h1234,4,1,0, 7,4));
    vt.push_back(mk(1,4'b0100,13, 0,0,0, 0,0, 0,0,1,'h1234,4,0,0, 8,5));
    // flush a full buffer with a concurrent CDB
    vt.push_back(mk(0,0,0, 1,5,'hBEEF, 1,0, 0,0,0,D,0,0,0, 0,0));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0,D,0,0,0, 0,0));
    // branch then mul
    vt.push_back(mk(1,4'b0100,14, 0,0,0, 0,0, 0,0,0,D,0,0,0, 1,1));
    vt.push_back(mk(1,4'b0010,15, 0,0,0, 0,0, 0,0,0,D,0,0,0, 2,2));
    vt.push_back(mk(0,0,0, 1,1,'h0BBB, 0,0, 0,0,0,D,0,0,0, 2,2));
    vt.push_back(mk(0,0,0, 1,0,'h0AAA, 0,0, 0,0,0,D,0,0,0, 2,2));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 1,0,14,'h0AAA,0,0,0, 1,2));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,15,'h0BBB,1,0,1, 0,2));
    // func 0011 (mul) and 0001 (add)
    vt.push_back(mk(1,4'b0011,3, 0,0,0, 0,0, 0,0,15,'h0BBB,1,0,0, 1,3));
    vt.push_back(mk(1,4'b0001,4, 1,2,'h3333, 0,0, 0,0,15,'h0BBB,1,0,0, 2,4));
    vt.push_back(mk(0,0,0, 1,3,'h4444, 0,0, 1,1,3,'h3333,2,0,1, 1,4));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,4,'h4444,3,1,0, 0,4));
    // CDB to the entry being allocated, CDB to an invalid entry, duplicate overwrite
    vt.push_back(mk(1,0,5, 1,4,'h5555, 0,0, 0,0,4,'h4444,3,0,0, 1,5));
    vt.push_back(mk(1,0,6, 1,6,'h6666, 0,0, 0,0,4,'h4444,3,0,0, 2,6));
    vt.push_back(mk(0,0,0, 1,5,'h0001, 0,0, 0,0,4,'h4444,3,0,0, 2,6));
    vt.push_back(mk(0,0,0, 1,5,'h0002, 0,0, 0,0,4,'h4444,3,0,0, 2,6));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,4,'h4444,3,0,0, 2,6));
    vt.push_back(mk(0,0,0, 1,4,'h0004, 0,0, 0,0,4,'h4444,3,0,0, 2,6));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,5,'h0004,4,1,0, 1,6));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 1,1,6,'h0002,5,1,0, 0,6));
    vt.push_back(mk(1,0,7, 0,0,0, 0,0, 0,0,6,'h0002,5,0,0, 1,7));
    vt.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,6,'h0002,5,0,0, 1,7));

    for (int i = 0; i < vt.size(); i++)
      run_vec($sformatf("vec%0d", i), vt[i]);

    // Flush with 5 entries (tags 6,7,0,1,2), tags 0 and 1 ready, plus a concurrent CDB and alloc
    for (int i = 0; i < 4; i++)
      run_vec($sformatf("flush_fill%0d", i),
              mk(1,0,8+i, 0,0,0, 0,0, 0,0,6,'h0002,5,0,0, 2+i,i));
    run_vec("flush_cdb0", mk(0,0,0, 1,0,'h00C0, 0,0, 0,0,6,'h0002,5,0,0, 5,3));
    run_vec("flush_cdb1", mk(0,0,0, 1,1,'h00C1, 0,0, 0,0,6,'h0002,5,0,0, 5,3));
    run_vec("flush_cycle", mk(1,0,12, 1,6,'h00C6, 1,0, 0,0,0,D,0,0,0, 0,0));
    for (int i = 0; i < 3; i++)
      run_vec($sformatf("flush_idle%0d", i), mk(0,0,0, 0,0,0, 0,0, 0,0,0,D,0,0,0, 0,0));
    run_vec("flush_realloc", mk(1,0,13, 0,0,0, 0,0, 0,0,0,D,0,0,0, 1,1));
    run_vec("flush_noretire", mk(0,0,0, 0,0,0, 0,0, 0,0,0,D,0,0,0, 1,1));

    // Mid-stream reset on the edge where head would retire
    run_vec("rst_alloc", mk(1,4'b0010,14, 0,0,0, 0,0, 0,0,0,D,0,0,0, 2,2));
    run_vec("rst_cdb",   mk(0,0,0, 1,0,'h0D00, 0,0, 0,0,0,D,0,0,0, 2,2));
    run_vec("rst_cycle", mk(1,0,15, 1,1,'h0EEE, 0,1, 0,0,0,0,0,0,0, 0,0));
    run_vec("rst_idle",  mk(0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0,0, 0,0));
    run_vec("post_alloc", mk(1,0,1, 0,0,0, 0,0, 0,0,0,0,0,0,0, 1,1));
    run_vec("post_cdb",   mk(0,0,0, 1,0,'h0101, 0,0, 0,0,0,0,0,0,0, 1,1));
    run_vec("post_commit", mk(0,0,0, 0,0,0, 0,0, 1,1,1,'h0101,0,1,0, 0,1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
